seg_scan: RTL and testbench

SEG_SCAN -- requirements
Module: seg_scan

---
 rtl/seg_scan.sv | 149 ++++++++++++++
 tb/tb_seg_scan.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/seg_scan.sv
//------------------------------------------------------------------------------
// seg_scan : time-multiplexed 7-segment digit scanner with double-buffered load
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module seg_scan #(
  parameter int DIGITS    = 8,
  parameter int DIV       = 4,
  parameter int BLANK_CYC = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [4*DIGITS-1:0]   ld_data,
  input  logic [DIGITS-1:0]     ld_dp,
  input  logic [DIGITS-1:0]     ld_en,
  output logic [DIGITS-1:0]     an,
  output logic                  dec_valid,
  output logic [3:0]            dec_data,
  output logic                  dec_p,
  output logic                  frame_done
);

  localparam int CNT_MAX = (DIV > BLANK_CYC) ? ((DIV > 2) ? DIV : 2)
                                             : ((BLANK_CYC > 2) ? BLANK_CYC : 2);
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam int IDX_W   = $clog2((DIGITS > 1) ? DIGITS : 2);
  localparam int BLK_END = (BLANK_CYC > 0) ? BLANK_CYC - 1 : 0;

  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] BLK_LAST = CNT_W'(BLK_END);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHOW  = 2'd1,
    S_BLANK = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  pending_q;
  logic [4*DIGITS-1:0]   sh_data_q, act_data_q;
  logic [DIGITS-1:0]     sh_dp_q, act_dp_q;
  logic [DIGITS-1:0]     sh_en_q, act_en_q;

  logic w_xfer, w_show_last, w_blank_last, w_slot_end, w_frame_end, w_commit;
  logic [DIGITS-1:0] w_en_next;

  assign w_xfer       = ld_valid & ~pending_q;
  assign w_show_last  = (state_q == S_SHOW)  && (cnt_q == DIV_LAST);
  assign w_blank_last = (state_q == S_BLANK) && (cnt_q == BLK_LAST);
  assign w_slot_end   = (BLANK_CYC == 0) ? w_show_last : w_blank_last;
  assign w_frame_end  = w_slot_end && (idx_q == IDX_LAST);
  // Commits only happen while idle or on the last cycle of a frame.
  assign w_commit     = pending_q && ((state_q == S_IDLE) || w_frame_end);
  assign w_en_next    = w_commit ? sh_en_q : act_en_q;
  assign ld_ready     = ~pending_q;
  assign frame_done   = w_frame_end;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q + CNT_W'(1);
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (w_commit && (|sh_en_q)) state_d = S_SHOW;
      end
      S_SHOW: begin
        if (w_show_last) begin
          cnt_d   = '0;
          state_d = S_BLANK;
        end
      end
      S_BLANK: ;
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase
    if (w_slot_end) begin
      cnt_d = '0;
      if (idx_q == IDX_LAST) begin
        idx_d   = '0;
        state_d = (|w_en_next) ? S_SHOW : S_IDLE;
      end else begin
        idx_d   = idx_q + IDX_W'(1);
        state_d = S_SHOW;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      pending_q  <= 1'b0;
      sh_data_q  <= '0;
      sh_dp_q    <= '0;
      sh_en_q    <= '0;
      act_data_q <= '0;
      act_dp_q   <= '0;
      act_en_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      if (w_xfer) begin
        sh_data_q <= ld_data;
        sh_dp_q   <= ld_dp;
        sh_en_q   <= ld_en;
        pending_q <= 1'b1;
      end else if (w_commit) begin
        pending_q <= 1'b0;
      end
      if (w_commit) begin
        act_data_q <= sh_data_q;
        act_dp_q   <= sh_dp_q;
        act_en_q   <= sh_en_q;
      end
    end
  end

  // Disabled digits still occupy their slot, just with the anode kept off.
  always_comb begin
    an        = '1;
    dec_valid = 1'b0;
    dec_data  = 4'h0;
    dec_p     = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if ((state_q == S_SHOW) && (idx_q == IDX_W'(i))) begin
        an[i]     = ~act_en_q[i];
        dec_valid = act_en_q[i];
        dec_data  = act_en_q[i] ? act_data_q[4*i +: 4] : 4'h0;
        dec_p     = act_en_q[i] & act_dp_q[i];
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seg_scan.sv
//------------------------------------------------------------------------------
// tb_seg_scan : scoreboard bench for seg_scan against a frame-timeline model
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_seg_scan;

  localparam int DIGITS    = 8;
  localparam int DIV       = 4;
  localparam int BLANK_CYC = 1;
  localparam int SLOT      = DIV + BLANK_CYC;
  localparam int FRAME     = DIGITS * SLOT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ld_valid = 1'b0;
  logic        ld_ready;
  logic [31:0] ld_data = '0;
  logic [7:0]  ld_dp = '0;
  logic [7:0]  ld_en = '0;
  logic [7:0]  an;
  logic        dec_valid;
  logic [3:0]  dec_data;
  logic        dec_p;
  logic        frame_done;

  seg_scan #(.DIGITS(DIGITS), .DIV(DIV), .BLANK_CYC(BLANK_CYC)) dut (
    .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_data(ld_data), .ld_dp(ld_dp), .ld_en(ld_en), .an(an),
    .dec_valid(dec_valid), .dec_data(dec_data), .dec_p(dec_p),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] an;
    logic       dv;
    logic [3:0] data;
    logic       p;
    logic       fd;
    logic       rdy;
  } exp_t;

  exp_t exp_q[$];
  int   n_total = 0;
  int   n_pass  = 0;

  // Reference model: position within the frame timeline plus the two buffers.
  bit          m_run, m_pend;
  int          m_t;
  logic [31:0] m_sh_d, m_act_d;
  logic [7:0]  m_sh_dp, m_act_dp, m_sh_en, m_act_en;

  task automatic model_reset();
    m_run = 0; m_pend = 0; m_t = 0;
    m_sh_d = '0; m_act_d = '0; m_sh_dp = '0; m_act_dp = '0; m_sh_en = '0; m_act_en = '0;
  endtask

  task automatic step(input bit r, input bit v, input logic [31:0] d,
                      input logic [7:0] p, input logic [7:0] e);
    exp_t x;
    int   slot, ph;
    bit   fe, commit, xfer;
    @(posedge clk);
    #1;
    rst = r; ld_valid = v; ld_data = d; ld_dp = p; ld_en = e;
    x.an = 8'hFF; x.dv = 0; x.data = 4'h0; x.p = 0; x.fd = 0; x.rdy = !m_pend;
    if (m_run) begin
      slot = m_t / SLOT;
      ph   = m_t % SLOT;
      x.fd = (m_t == FRAME - 1);
      if (ph < DIV && m_act_en[slot]) begin
        x.an   = ~(8'h01 << slot);
        x.dv   = 1;
        x.data = m_act_d[slot*4 +: 4];
        x.p    = m_act_dp[slot];
      end
    end
    exp_q.push_back(x);
    if (r) begin
      model_reset();
    end else begin
      fe     = m_run && (m_t == FRAME - 1);
      commit = m_pend && (!m_run || fe);
      xfer   = v && !m_pend;
      if (commit) begin
        m_act_d = m_sh_d; m_act_dp = m_sh_dp; m_act_en = m_sh_en;
      end
      if (!m_run) begin
        if (commit) begin
          m_run = (m_act_en != 0);
          m_t   = 0;
        end
      end else if (fe) begin
        m_t   = 0;
        m_run = (m_act_en != 0);
      end else begin
        m_t++;
      end
      if (xfer) begin
        m_sh_d = d; m_sh_dp = p; m_sh_en = e; m_pend = 1;
      end else if (commit) begin
        m_pend = 0;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 32'h0, 8'h0, 8'h0);
  endtask

  // Monitor: every cycle the DUT presents a display state, compare it.
  initial begin
    exp_t x, a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        a.an = an; a.dv = dec_valid; a.data = dec_data; a.p = dec_p;
        a.fd = frame_done; a.rdy = ld_ready;
        n_total++;
        if (a === x) n_pass++;
        else $display("FAIL cycle_check @%0t: got an=%h dv=%b data=%h p=%b fd=%b rdy=%b, want an=%h dv=%b data=%h p=%b fd=%b rdy=%b",
                      $time, a.an, a.dv, a.data, a.p, a.fd, a.rdy,
                      x.an, x.dv, x.data, x.p, x.fd, x.rdy);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    model_reset();
    @(posedge clk);
    #1;
    step(1, 1, 32'hDEADBEEF, 8'hFF, 8'hFF);
    idle(2);

    // First load in idle, then free-run across several frames.
    step(0, 1, 32'h89ABCDEF, 8'h00, 8'hFF);
    idle(3 * FRAME + 7);

    // Mid-frame load with the upper digits disabled.
    step(0, 1, 32'h0000_0000, 8'h0F, 8'h0F);
    idle(2 * FRAME);

    // Reset during digit 3 with a load still pending.
    k = 0;
    while (!(m_run && m_t == 0) && k < 2 * FRAME) begin idle(1); k++; end
    step(0, 1, 32'h1234_5678, 8'hA5, 8'hFF);
    k = 0;
    while (!(m_run && m_t == 3 * SLOT + 1) && k < 2 * FRAME) begin idle(1); k++; end
    step(1, 0, 32'h0, 8'h0, 8'h0);
    idle(5);

    // Run, then blank everything, then restart a single digit.
    step(0, 1, 32'hFEDC_BA98, 8'h3C, 8'hFF);
    idle(FRAME / 2);
    step(0, 1, 32'h5555_5555, 8'h00, 8'h00);
    idle(2 * FRAME + 10);
    step(0, 1, 32'h0000_000C, 8'h01, 8'h01);
    idle(2 * FRAME);

    // ld_valid held high with changing contents.
    for (int i = 0; i < 4 * FRAME; i++)
      step(0, 1, $urandom, 8'($urandom), 8'($urandom) | 8'h01);

    // Fully random traffic including occasional resets and empty masks.
    for (int i = 0; i < 3000; i++)
      step(($urandom % 200) == 0, ($urandom % 6) == 0, $urandom, 8'($urandom),
           (($urandom % 5) == 0) ? 8'h00 : 8'($urandom));
    idle(3);

    k = 0;
    while (exp_q.size() > 0 && k < 10) begin @(posedge clk); k++; end
    if (exp_q.size() > 0) begin
      n_total++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
